// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: controller states, opcodes
// and the datapath select encodings (alu_op values are shared with the ALU decoder).
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WRITE = 4'd4,
    S_MEM_WB    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main sequencing FSM of the multicycle RV32I core: drives datapath selects and
// strobes, handles the stallable memory handshake and counts retired instructions.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | read registers, ALU forms OldPC+imm branch/jump target
// MEM_ADR   | ALU forms rs1+imm load/store address
// MEM_READ  | load request, waits for mem_ready
// MEM_WRITE | store request, waits for mem_ready, retires
// MEM_WB    | write loaded data to rd, retires
// EXEC_R    | register-register ALU operation
// EXEC_I    | register-immediate ALU operation
// ALU_WB    | write ALU-out to rd, retires
// BEQ       | compare rs1-rs2, take target when zero, retires
// JAL       | ALU forms OldPC+4 link value, PC <= target
module multicycle_control_fsm
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_nxt;
  logic   retire;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    retire        = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;

    if (!rst_n) begin
      // Strobes stay low; selects idle at their FETCH values.
      state_nxt  = S_FETCH;
      result_src = RES_ALU;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
      alu_op     = ALUOP_ADD;
    end else begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          adr_src    = 1'b0;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALUOP_ADD;
          result_src = RES_ALU;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_update = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          case (op)
            OP_LW, OP_SW: state_nxt = S_MEM_ADR;
            OP_R:         state_nxt = S_EXEC_R;
            OP_IALU:      state_nxt = S_EXEC_I;
            OP_BEQ:       state_nxt = S_BEQ;
            OP_JAL:       state_nxt = S_JAL;
            default: begin
              illegal_instr = 1'b1;
              state_nxt     = S_FETCH;
            end
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          state_nxt = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        end
        S_MEM_WB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
          retire     = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALUOP_FUNCT;
          state_nxt = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_FUNCT;
          state_nxt = S_ALU_WB;
        end
        S_ALU_WB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
          state_nxt  = S_FETCH;
          retire     = 1'b1;
        end
        S_BEQ: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALUOP_SUB;
          result_src = RES_ALUOUT;
          branch     = 1'b1;
          state_nxt  = S_FETCH;
          retire     = 1'b1;
        end
        S_JAL: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALUOP_ADD;
          result_src = RES_ALUOUT;
          pc_update  = 1'b1;
          state_nxt  = S_ALU_WB;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle control vectors checked
// against hand-built expectations, with stalls, reset abandon and counter wrap.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             illegal_instr;
  logic [CNT_W-1:0] instret;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_instr (illegal_instr),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_op, illegal_instr}
  localparam logic [14:0] V_RST     = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_FETCH   = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_FETCH_W = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_DECODE  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_ILLEGAL = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1};
  localparam logic [14:0] V_MEM_ADR = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_MEM_RD  = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEM_WR  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MEM_WB  = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_EXEC_R  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] V_EXEC_I  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [14:0] V_ALU_WB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_BEQ_T   = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] V_BEQ_N   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] V_JAL     = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;

  logic [14:0] ctrl;
  assign ctrl = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check the control vector before the edge, then advance.
  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [14:0] exp);
    mem_ready = rdy;
    zero      = z;
    #1;
    check_val(tag, {17'd0, ctrl}, {17'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    op        = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;

    cyc("reset_strobes", 1'b1, 1'b1, V_RST);
    check_val("reset_instret", 32'(instret), 32'd0);
    rst_n = 1'b1;

    op = LW;
    cyc("lw_fetch",   1'b1, 1'b0, V_FETCH);
    cyc("lw_decode",  1'b1, 1'b0, V_DECODE);
    cyc("lw_memadr",  1'b1, 1'b0, V_MEM_ADR);
    cyc("lw_memread", 1'b1, 1'b0, V_MEM_RD);
    check_val("lw_instret_before", 32'(instret), 32'd0);
    cyc("lw_memwb",   1'b0, 1'b0, V_MEM_WB);
    check_val("lw_instret", 32'(instret), 32'd1);

    op = SW;
    cyc("sw_fetch",   1'b1, 1'b0, V_FETCH);
    cyc("sw_decode",  1'b1, 1'b0, V_DECODE);
    cyc("sw_memadr",  1'b1, 1'b0, V_MEM_ADR);
    for (int i = 0; i < 3; i++) cyc("sw_stall", 1'b0, 1'b0, V_MEM_WR);
    check_val("sw_instret_stalled", 32'(instret), 32'd1);
    cyc("sw_memwrite", 1'b1, 1'b0, V_MEM_WR);
    check_val("sw_instret", 32'(instret), 32'd2);

    op = BEQ;
    cyc("beq1_fetch",  1'b1, 1'b0, V_FETCH);
    cyc("beq1_decode", 1'b1, 1'b1, V_DECODE);
    cyc("beq1_taken",  1'b1, 1'b1, V_BEQ_T);
    cyc("beq2_fetch",  1'b1, 1'b0, V_FETCH);
    cyc("beq2_decode", 1'b1, 1'b0, V_DECODE);
    cyc("beq2_not",    1'b1, 1'b0, V_BEQ_N);
    check_val("beq_instret", 32'(instret), 32'd4);

    op = RT;
    cyc("r_fetch_wait", 1'b0, 1'b0, V_FETCH_W);
    cyc("r_fetch",      1'b1, 1'b0, V_FETCH);
    cyc("r_decode",     1'b0, 1'b0, V_DECODE);
    cyc("r_exec",       1'b0, 1'b0, V_EXEC_R);
    cyc("r_wb",         1'b1, 1'b0, V_ALU_WB);
    op = IALU;
    cyc("i_fetch",  1'b1, 1'b0, V_FETCH);
    cyc("i_decode", 1'b1, 1'b0, V_DECODE);
    cyc("i_exec",   1'b1, 1'b0, V_EXEC_I);
    cyc("i_wb",     1'b1, 1'b0, V_ALU_WB);
    check_val("ri_instret", 32'(instret), 32'd6);

    op = JAL;
    cyc("jal_fetch",  1'b1, 1'b0, V_FETCH);
    cyc("jal_decode", 1'b1, 1'b0, V_DECODE);
    cyc("jal_jal",    1'b1, 1'b0, V_JAL);
    cyc("jal_wb",     1'b1, 1'b0, V_ALU_WB);
    check_val("jal_instret", 32'(instret), 32'd7);

    op = 7'b0000000;
    cyc("ill_fetch",  1'b1, 1'b0, V_FETCH);
    cyc("ill_decode", 1'b1, 1'b0, V_ILLEGAL);
    check_val("ill_instret", 32'(instret), 32'd7);

    op = LW;
    cyc("rlw_fetch",   1'b1, 1'b0, V_FETCH);
    cyc("rlw_decode",  1'b1, 1'b0, V_DECODE);
    cyc("rlw_memadr",  1'b1, 1'b0, V_MEM_ADR);
    cyc("rlw_stall",   1'b0, 1'b0, V_MEM_RD);
    rst_n = 1'b0;
    cyc("rlw_reset",   1'b0, 1'b0, V_RST);
    rst_n = 1'b1;
    check_val("rlw_instret", 32'(instret), 32'd0);
    cyc("rlw_refetch", 1'b0, 1'b0, V_FETCH_W);

    op = BEQ;
    for (int i = 0; i < 15; i++) begin
      cyc("wrap_fetch",  1'b1, 1'b0, V_FETCH);
      cyc("wrap_decode", 1'b1, 1'b0, V_DECODE);
      cyc("wrap_beq",    1'b1, 1'b0, V_BEQ_N);
    end
    check_val("wrap_instret_15", 32'(instret), 32'd15);
    cyc("wrap_fetch",  1'b1, 1'b0, V_FETCH);
    cyc("wrap_decode", 1'b1, 1'b0, V_DECODE);
    cyc("wrap_beq",    1'b1, 1'b0, V_BEQ_N);
    check_val("wrap_instret_0", 32'(instret), 32'd0);
    cyc("final_fetch", 1'b1, 1'b0, V_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle RV32I core; it sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and write strobes, and it produces the 2-bit `alu_op` consumed directly by the ALU decoder downstream. It handles a stallable memory handshake and keeps a retired-instruction counter.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `op  in  7`: `instr[6:0]` from the instruction register.
- `zero  in  1`: ALU zero flag.
- `mem_ready  in  1`: memory has completed the current request in this cycle.
- `mem_req  out  1`: memory request is valid.
- `adr_src  out  1`: memory address select. 0 = PC, 1 = ALU-out register.
- `mem_write  out  1`: memory write enable, qualified by `mem_req`.
- `ir_write  out  1`: load the instruction register and OldPC.
- `pc_write  out  1`: PC load enable, equal to `pc_update | (branch & zero)`.
- `reg_write  out  1`: register file write enable.
- `result_src  out  2`: result mux select. 00 = ALU-out, 01 = data register, 10 = ALU result.
- `alu_src_a  out  2`: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b  out  2`: ALU B select. 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op  out  2`: 00 = add, 01 = subtract (compare), 10 = funct-decoded.
- `illegal_instr  out  1`: one-cycle pulse when an unsupported opcode is decoded.
- `instret  out  CNT_W`: count of retired instructions.

## Operation
- Supported opcodes: LW 0000011, SW 0100011, R 0110011, I-ALU 0010011, BEQ 1100011, JAL 1101111.
- Outputs are Moore-decoded from the state. The exceptions are `ir_write`, the FETCH `pc_update`, and all transitions out of memory states, which are qualified by `mem_ready`.
- Any output not listed for a state is 0 (selects and strobes alike).
- States and their outputs:
  - FETCH: `mem_req=1`, `adr_src=0`, `alu_src_a=00`, `alu_src_b=10`, `alu_op=00`, `result_src=10`. `ir_write` and `pc_update` assert only when `mem_ready=1`. Stays in FETCH while `mem_ready=0`; moves to DECODE when `mem_ready=1`.
  - DECODE: `alu_src_a=01`, `alu_src_b=01`, `alu_op=00` (computes the branch/jump target). Next state by opcode: LW/SW → MEM_ADR, R → EXEC_R, I-ALU → EXEC_I, BEQ → BEQ, JAL → JAL. Any other opcode pulses `illegal_instr` and returns to FETCH.
  - MEM_ADR: `alu_src_a=10`, `alu_src_b=01`, `alu_op=00`. Goes to MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ: `mem_req=1`, `adr_src=1`. Moves to MEM_WB on `mem_ready`.
  - MEM_WRITE: `mem_req=1`, `mem_write=1`, `adr_src=1`. Moves to FETCH on `mem_ready` (retire).
  - MEM_WB: `result_src=01`, `reg_write=1`. Goes to FETCH (retire).
  - EXEC_R: `alu_src_a=10`, `alu_src_b=00`, `alu_op=10`. Goes to ALU_WB.
  - EXEC_I: `alu_src_a=10`, `alu_src_b=01`, `alu_op=10`. Goes to ALU_WB.
  - ALU_WB: `result_src=00`, `reg_write=1`. Goes to FETCH (retire).
  - BEQ: `alu_src_a=10`, `alu_src_b=00`, `alu_op=01`, `result_src=00`, `branch=1`. Goes to FETCH (retire).
  - JAL: `alu_src_a=01`, `alu_src_b=10`, `alu_op=00`, `result_src=00`, `pc_update=1`. Goes to ALU_WB.
- `instret` increments by 1 on each retiring transition into FETCH and wraps modulo 2^CNT_W. An illegal opcode does not retire.

## Timing
- Reset: while `rst_n=0` at a rising edge, the next state is FETCH and `instret` becomes 0.
- During reset, `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write` and `illegal_instr` are forced to 0. The selects show their FETCH values.
- Reset asserted mid-instruction (including a stalled memory state) abandons the instruction with no further strobes and does not retire it.
- Latency with `mem_ready` always 1: LW 5 cycles, SW 4, R 4, I-ALU 4, JAL 4, BEQ 3, illegal 2.
- Every `mem_ready=0` cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `mem_req` stays asserted and the address and data selects stay stable until `mem_ready`.
- `mem_ready` is ignored in all other states.
- `pc_write` is combinational from the state, `zero` and `mem_ready`.

## Structure
- Shared package `riscv_pkg` holds:
  - the `state_t` enum;
  - opcode localparams;
  - encodings for `result_src`, `alu_src_a`, `alu_src_b` and `alu_op`, with the `alu_op` values shared with the ALU decoder.
- Single module with two processes: a registered state and counter process, and a combinational next-state and output process. No sub-module.

## Test plan
- Reset, then LW with `mem_ready=1`: states FETCH→DECODE→MEM_ADR→MEM_READ→MEM_WB→FETCH; `reg_write=1` only in cycle 5 with `result_src=01`; `instret` 0→1.
- SW with `mem_ready` low for 3 cycles in MEM_WRITE: `mem_req=1` and `mem_write=1` for 4 cycles; SW total 7 cycles; no `reg_write`.
- BEQ with `zero=1`, then BEQ with `zero=0`: `pc_write=1` only in the BEQ state of the first; `alu_op=01` in both.
- R-type then I-ALU: `alu_op=10` in EXEC_R and EXEC_I; `alu_src_b=00` and `01` respectively.
- JAL: `pc_write=1` in the JAL state, `reg_write=1` in the next cycle with `result_src=00`. Opcode 0000000: `illegal_instr` pulses once in DECODE, returns to FETCH, `instret` unchanged.
- `rst_n=0` during a stalled MEM_READ: next cycle is FETCH, all strobes 0, `instret=0`. Counter preset near `2^CNT_W-1` (e.g., `CNT_W=4`, 15 retires then 1 more) wraps to 0.
